// File: rtl/isp_pkg.sv
// Shared definitions for the ISP white-balance blocks: colour codes, gain
// constants, the AWB controller state encoding and the gain helper functions.
package isp_pkg;

  localparam logic [1:0] RED   = 2'd0;
  localparam logic [1:0] GREEN = 2'd1;
  localparam logic [1:0] BLUE  = 2'd2;

  localparam logic [15:0] GAIN_UNITY = 16'h0100;
  localparam logic [15:0] GAIN_MAX   = 16'h0FFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DIV_R,
    ST_DIV_B,
    ST_UPDATE
  } awb_state_t;

  // Turns a raw divider result into a usable gain: degenerate statistics give
  // unity, anything beyond the WB stage's range is pinned to GAIN_MAX.
  function automatic logic [15:0] div_to_gain(input logic degenerate,
                                               input logic ovf,
                                               input logic [15:0] quo);
    if (degenerate)
      return GAIN_UNITY;
    else if (ovf || (quo > GAIN_MAX))
      return GAIN_MAX;
    else
      return quo;
  endfunction

  // One step of the first-order smoothing filter: move half way from the
  // current gain toward the freshly computed one, clamped to [0, GAIN_MAX].
  function automatic logic [15:0] iir_step(input logic [15:0] k_old,
                                           input logic [15:0] k_calc);
    logic signed [17:0] diff;
    logic signed [17:0] next;
    diff = $signed({2'b00, k_calc}) - $signed({2'b00, k_old});
    next = $signed({2'b00, k_old}) + (diff >>> 1);
    if (next < 18'sd0)
      return 16'h0000;
    else if (next > $signed({2'b00, GAIN_MAX}))
      return GAIN_MAX;
    else
      return next[15:0];
  endfunction

endpackage

// File: rtl/awb_div_seq.sv
// Restoring unsigned divider producing one quotient bit per clock.
// A start pulse loads the operands; QW cycles later done pulses for one cycle
// with quo/ovf valid and held until the next start. ovf flags quotients that
// do not fit in QW bits (num >= den << QW).
module awb_div_seq #(
  parameter int NW = 48,
  parameter int DW = 40,
  parameter int QW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          done,
  output logic [QW-1:0] quo,
  output logic          ovf
);
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(QW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [DW-1:0] rem;
  logic [DW-1:0] den_q;
  logic [QW-1:0] lo;
  logic [CW-1:0] cnt;
  logic [DW:0]   trial;
  logic [DW:0]   diff;
  logic          ovf_now;

  // Trial subtraction for the current quotient bit and load-time overflow test.
  always_comb begin
    trial   = {rem, lo[QW-1]};
    diff    = trial - {1'b0, den_q};
    ovf_now = ((DW + QW)'(num) >= {den, {QW{1'b0}}});
  end

  // Iteration register: load on start, then shift one quotient bit per cycle.
  // NOTE: clocked state is written with <= only, so every register samples the
  // pre-edge values and the order of statements inside the block is irrelevant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      den_q <= '0;
      lo    <= '0;
      cnt   <= '0;
      quo   <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Upper numerator bits seed the remainder; they are < den unless ovf.
        rem   <= DW'(num[NW-1:QW]);
        lo    <= num[QW-1:0];
        den_q <= den;
        cnt   <= CNT_INIT;
        quo   <= '0;
        ovf   <= ovf_now;
      end else if (cnt != '0) begin
        if (trial >= {1'b0, den_q}) begin
          rem <= diff[DW-1:0];
          quo <= {quo[QW-2:0], 1'b1};
        end else begin
          rem <= trial[DW-1:0];
          quo <= {quo[QW-2:0], 1'b0};
        end
        lo  <= lo << 1;
        cnt <= cnt - CNT_ONE;
        if (cnt == CNT_ONE)
          done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/awb_gain_ctrl.sv
// Gray-world auto-white-balance controller. Accumulates per-channel sums and
// pixel counts over a frame, then divides G-relative ratios for R and B on a
// shared sequential divider and publishes Q8.8 gains to the WB stage.
// Gain ports are 16 bits wide, so QW is expected to stay at 16.
// Optional build macro: AWB_IIR_EN smooths successive gain updates.
module awb_gain_ctrl
  import isp_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 16,
  parameter int QW    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start_i,
  input  logic        frame_end_i,
  input  logic        valid_i,
  input  logic [1:0]  color_i,
  input  logic [7:0]  value_i,
  output logic [15:0] K_R,
  output logic [15:0] K_G,
  output logic [15:0] K_B,
  output logic        valid_gain_o,
  output logic        gain_updt_o,
  output logic        busy_o
);
  localparam int DW = ACC_W + CNT_W;
  localparam int NW = DW + 8;

  awb_state_t       state;
  logic [ACC_W-1:0] sum_q   [3];
  logic [CNT_W-1:0] cnt_q   [3];
  logic [ACC_W-1:0] sum_nxt [3];
  logic [CNT_W-1:0] cnt_nxt [3];
  logic             restart;
  logic             pix_ok;
  logic             start_q;
  logic             div_start;
  logic             div_done;
  logic             div_ovf;
  logic [QW-1:0]    div_quo;
  logic [ACC_W-1:0] s_op;
  logic [CNT_W-1:0] n_op;
  logic [DW-1:0]    num_prod;
  logic [DW-1:0]    den_prod;
  logic [NW-1:0]    div_num;
  logic             zero_r;
  logic             zero_b;
  logic [15:0]      kr_hold;
  logic [15:0]      kb_calc;

  function automatic logic [ACC_W-1:0] sat_sum(input logic [ACC_W-1:0] a,
                                               input logic [7:0] v);
    logic [ACC_W:0] t;
    t = {1'b0, a} + (ACC_W + 1)'(v);
    return t[ACC_W] ? '1 : t[ACC_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] a);
    return (&a) ? a : a + CNT_W'(1);
  endfunction

  assign K_G = GAIN_UNITY;

  // Next-value statistics: optional restart clear, then the qualified pixel.
  // NOTE: every always_comb output gets a default before any condition, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    restart = (state == ST_ACCUM) && frame_start_i && !frame_end_i;
    pix_ok  = (state == ST_ACCUM) && valid_i && (color_i != 2'd3);
    for (int c = 0; c < 3; c++) begin
      sum_nxt[c] = restart ? '0 : sum_q[c];
      cnt_nxt[c] = restart ? '0 : cnt_q[c];
      if (pix_ok && (color_i == 2'(c))) begin
        sum_nxt[c] = sat_sum(sum_nxt[c], value_i);
        cnt_nxt[c] = sat_cnt(cnt_nxt[c]);
      end
    end
  end

  // Statistics registers: cleared on frame start from IDLE, updated in ACCUM.
  // NOTE: this small register array is reset explicitly because a reset must
  // discard a partially accumulated frame, unlike storage arrays left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '{default: '0};
      cnt_q <= '{default: '0};
    end else if ((state == ST_IDLE) && frame_start_i) begin
      sum_q <= '{default: '0};
      cnt_q <= '{default: '0};
    end else if (state == ST_ACCUM) begin
      sum_q <= sum_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // Divider operands: R on the first start, B when the R result completes.
  always_comb begin
    s_op      = start_q ? sum_q[RED] : sum_q[BLUE];
    n_op      = start_q ? cnt_q[RED] : cnt_q[BLUE];
    num_prod  = DW'(sum_q[GREEN]) * DW'(n_op);
    den_prod  = DW'(s_op) * DW'(cnt_q[GREEN]);
    div_num   = {num_prod, 8'h00};
    div_start = start_q || ((state == ST_DIV_R) && div_done);
    zero_r    = (sum_q[RED] == '0) || (cnt_q[RED] == '0) || (cnt_q[GREEN] == '0);
    zero_b    = (sum_q[BLUE] == '0) || (cnt_q[BLUE] == '0) || (cnt_q[GREEN] == '0);
    kb_calc   = div_to_gain(zero_b, div_ovf, 16'(div_quo));
  end

  awb_div_seq #(
    .NW (NW),
    .DW (DW),
    .QW (QW)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (div_num),
    .den   (den_prod),
    .done  (div_done),
    .quo   (div_quo),
    .ovf   (div_ovf)
  );

  // Control FSM with registered gain, valid, update and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      start_q      <= 1'b0;
      kr_hold      <= GAIN_UNITY;
      K_R          <= GAIN_UNITY;
      K_B          <= GAIN_UNITY;
      valid_gain_o <= 1'b0;
      gain_updt_o  <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      start_q     <= 1'b0;
      gain_updt_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start_i)
            state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (frame_end_i) begin
            state   <= ST_DIV_R;
            start_q <= 1'b1;
            busy_o  <= 1'b1;
          end
        end
        ST_DIV_R: begin
          if (div_done) begin
            kr_hold <= div_to_gain(zero_r, div_ovf, 16'(div_quo));
            state   <= ST_DIV_B;
          end
        end
        ST_DIV_B: begin
          if (div_done) begin
`ifdef AWB_IIR_EN
            K_R <= valid_gain_o ? iir_step(K_R, kr_hold) : kr_hold;
            K_B <= valid_gain_o ? iir_step(K_B, kb_calc) : kb_calc;
`else
            K_R <= kr_hold;
            K_B <= kb_calc;
`endif
            valid_gain_o <= 1'b1;
            gain_updt_o  <= 1'b1;
            state        <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_awb_gain_ctrl.sv
// Self-checking bench for awb_gain_ctrl: a frame-level reference model plus a
// per-cycle compare process, directed corner cases and randomized frames.
module tb_awb_gain_ctrl;

  localparam bit IIR =
`ifdef AWB_IIR_EN
    1'b1;
`else
    1'b0;
`endif
  localparam longint SUM_MAX = (64'd1 << 24) - 1;
  localparam longint CNT_MAX = 65535;
  localparam int     LATENCY = 35;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs;
  logic        fe;
  logic        valid;
  logic [1:0]  color;
  logic [7:0]  value;
  logic [15:0] k_r;
  logic [15:0] k_g;
  logic [15:0] k_b;
  logic        valid_gain;
  logic        gain_updt;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  awb_gain_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start_i (fs),
    .frame_end_i   (fe),
    .valid_i       (valid),
    .color_i       (color),
    .value_i       (value),
    .K_R           (k_r),
    .K_G           (k_g),
    .K_B           (k_b),
    .valid_gain_o  (valid_gain),
    .gain_updt_o   (gain_updt),
    .busy_o        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint      m_s [3];
  longint      m_n [3];
  int          m_mode;   // 0 idle, 1 collecting, 2 computing
  int          m_edges;
  logic [15:0] m_kr;
  logic [15:0] m_kb;
  logic [15:0] m_pend_r;
  logic [15:0] m_pend_b;
  bit          m_valid;
  bit          m_updt;

  function automatic logic [15:0] ref_gain(longint sc, longint nc, longint sg, longint ng);
    longint q;
    if (sc == 0 || nc == 0 || ng == 0) return 16'h0100;
    q = (sg * nc * 256) / (sc * ng);
    return (q > 64'h0FFF) ? 16'h0FFF : 16'(q);
  endfunction

  function automatic logic [15:0] ref_apply(input logic [15:0] kold, input logic [15:0] kcalc,
                                            input bit first);
    int d;
    if (!IIR || first) return kcalc;
    d = int'(kcalc) - int'(kold);
    d = int'(kold) + (d >>> 1);
    if (d < 0) d = 0;
    if (d > 'h0FFF) d = 'h0FFF;
    return 16'(d);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      m_s[c] = 0;
      m_n[c] = 0;
    end
  endtask

  task automatic model_step();
    m_updt = 1'b0;
    if (rst) begin
      model_clear();
      m_mode  = 0;
      m_edges = 0;
      m_kr    = 16'h0100;
      m_kb    = 16'h0100;
      m_valid = 1'b0;
    end else begin
      case (m_mode)
        0: if (fs) begin model_clear(); m_mode = 1; end
        1: begin
          if (fs && !fe) model_clear();
          if (valid && color != 2'd3) begin
            m_s[color] = (m_s[color] + value > SUM_MAX) ? SUM_MAX : m_s[color] + value;
            m_n[color] = (m_n[color] + 1 > CNT_MAX) ? CNT_MAX : m_n[color] + 1;
          end
          if (fe) begin
            m_pend_r = ref_gain(m_s[0], m_n[0], m_s[1], m_n[1]);
            m_pend_b = ref_gain(m_s[2], m_n[2], m_s[1], m_n[1]);
            m_mode   = 2;
            m_edges  = 0;
          end
        end
        default: begin
          m_edges++;
          if (m_edges == LATENCY) begin
            m_kr    = ref_apply(m_kr, m_pend_r, !m_valid);
            m_kb    = ref_apply(m_kb, m_pend_b, !m_valid);
            m_valid = 1'b1;
            m_updt  = 1'b1;
          end
          if (m_edges == LATENCY + 1) m_mode = 0;
        end
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("cyc_K_R", k_r, m_kr);
      check("cyc_K_G", k_g, 16'h0100);
      check("cyc_K_B", k_b, m_kb);
      check("cyc_valid_gain", valid_gain, m_valid);
      check("cyc_gain_updt", gain_updt, m_updt);
      check("cyc_busy", busy, m_mode == 2);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit s, input bit e, input bit v, input logic [1:0] c,
                       input logic [7:0] x);
    fs = s; fe = e; valid = v; color = c; value = x;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) drive(0, 0, 0, 2'd0, 8'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fs = 0; fe = 0; valid = 0; color = 0; value = 0;
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic px_n(input logic [1:0] c, input logic [7:0] x, input int n);
    repeat (n) drive(0, 0, 1, c, x);
  endtask

  task automatic count_pulses(input int n, output int pulses, output int first_k);
    pulses = 0;
    first_k = -1;
    for (int k = 1; k <= n; k++) begin
      drive(0, 0, 0, 2'd0, 8'd0);
      if (gain_updt) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
  endtask

  task automatic end_and_wait(input string tag);
    int pulses;
    int first_k;
    drive(0, 1, 0, 2'd0, 8'd0);
    count_pulses(45, pulses, first_k);
    check({tag, "_latency"}, first_k, LATENCY);
    check({tag, "_pulses"}, pulses, 1);
  endtask

  task automatic cast_frame(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    drive(1, 0, 0, 2'd0, 8'd0);
    px_n(2'd0, r, 4);
    px_n(2'd1, g, 4);
    px_n(2'd2, b, 4);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int pulses;
    int first_k;
    int maxv [3];
    int npx;

    do_reset();
    check("rst_K_R", k_r, 16'h0100);
    check("rst_K_G", k_g, 16'h0100);
    check("rst_K_B", k_b, 16'h0100);
    check("rst_valid", valid_gain, 0);
    check("rst_busy", busy, 0);

    // Gray frame.
    drive(1, 0, 0, 2'd0, 8'd0);
    drive(0, 0, 1, 2'd0, 8'd100);
    px_n(2'd1, 8'd100, 2);
    drive(0, 0, 1, 2'd2, 8'd100);
    end_and_wait("gray");
    check("gray_K_R", k_r, 16'h0100);
    check("gray_K_B", k_b, 16'h0100);
    check("gray_valid", valid_gain, 1);

    // Colour cast.
    do_reset();
    cast_frame(8'd50, 8'd100, 8'd200);
    end_and_wait("cast");
    check("cast_K_R", k_r, 16'h0200);
    check("cast_K_G", k_g, 16'h0100);
    check("cast_K_B", k_b, 16'h0080);

    // Edge A: red sum zero -> unity; no blue pixels -> unity.
    do_reset();
    drive(1, 0, 0, 2'd0, 8'd0);
    px_n(2'd0, 8'd0, 4);
    px_n(2'd1, 8'd100, 4);
    end_and_wait("zero");
    check("zero_K_R", k_r, 16'h0100);
    check("zero_K_B", k_b, 16'h0100);

    // Edge B: quotient 0xFF00 clamps.
    do_reset();
    drive(1, 0, 0, 2'd0, 8'd0);
    drive(0, 0, 1, 2'd0, 8'd1);
    drive(0, 0, 1, 2'd1, 8'd255);
    end_and_wait("clamp");
    check("clamp_K_R", k_r, 16'h0FFF);

    // Restart mid-frame: only pixels from the restart cycle onward count.
    do_reset();
    drive(1, 0, 0, 2'd0, 8'd0);
    px_n(2'd0, 8'd10, 4);
    px_n(2'd1, 8'd200, 3);
    drive(1, 0, 1, 2'd0, 8'd50);
    px_n(2'd0, 8'd50, 3);
    px_n(2'd1, 8'd100, 4);
    px_n(2'd2, 8'd200, 4);
    end_and_wait("restart");
    check("restart_K_R", k_r, 16'h0200);
    check("restart_K_B", k_b, 16'h0080);

    // frame_end in IDLE does nothing.
    drive(0, 1, 0, 2'd0, 8'd0);
    count_pulses(40, pulses, first_k);
    check("idle_end_pulses", pulses, 0);
    check("idle_end_K_R", k_r, 16'h0200);

    // Reset during the B divide.
    drive(1, 0, 0, 2'd0, 8'd0);
    px_n(2'd0, 8'd50, 2);
    px_n(2'd1, 8'd100, 2);
    drive(0, 1, 0, 2'd0, 8'd0);
    idle_cycles(25);
    do_reset();
    check("middiv_K_R", k_r, 16'h0100);
    check("middiv_K_B", k_b, 16'h0100);
    check("middiv_valid", valid_gain, 0);
    check("middiv_busy", busy, 0);
    count_pulses(40, pulses, first_k);
    check("middiv_pulses", pulses, 0);

    // Two successive updates: direct load, then optional smoothing.
    do_reset();
    cast_frame(8'd50, 8'd100, 8'd200);
    end_and_wait("seq1");
    check("seq1_K_R", k_r, 16'h0200);
    cast_frame(8'd100, 8'd100, 8'd100);
    end_and_wait("seq2");
    check("seq2_K_R", k_r, IIR ? 16'h0180 : 16'h0100);
    check("seq2_K_B", k_b, IIR ? 16'h00C0 : 16'h0100);

    // Randomized frames with restarts, ignored inputs and simultaneous events.
    for (int f = 0; f < 40; f++) begin
      for (int c = 0; c < 3; c++)
        maxv[c] = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 255);
      drive(1, 0, 0, 2'd0, 8'd0);
      npx = $urandom_range(1, 40);
      for (int i = 0; i < npx; i++) begin
        color = 2'($urandom_range(0, 3));
        drive($urandom_range(0, 24) == 0, 0, $urandom_range(0, 3) != 0, color,
              8'($urandom_range(0, maxv[color == 2'd3 ? 0 : color])));
      end
      color = 2'($urandom_range(0, 2));
      drive($urandom_range(0, 3) == 0, 1, $urandom_range(0, 1), color,
            8'($urandom_range(0, maxv[color])));
      for (int k = 0; k < 30; k++)
        drive($urandom_range(0, 7) == 0, 0, $urandom_range(0, 1),
              2'($urandom_range(0, 3)), 8'($urandom));
      idle_cycles(10);
      if ($urandom_range(0, 3) == 0) drive(0, 1, 0, 2'd0, 8'd0);
    end

    idle_cycles(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
